// File: rtl/systolic_mac_array_nxn.sv
// Output-stationary NxN systolic MAC array with built-in skew, flush sequencing
// and a row-by-row valid/ready result drain.
module systolic_mac_array_nxn #(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int K_W    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [K_W-1:0]       k_len,
   input  logic                 signed_mode,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [N*DATA_W-1:0]  a_vec,
   input  logic [N*DATA_W-1:0]  b_vec,
   output logic                 busy,
   output logic                 done,
   output logic                 c_valid,
   input  logic                 c_ready,
   output logic [$clog2(N)-1:0] c_row_idx,
   output logic [N*ACC_W-1:0]   c_row
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   localparam int IDX_W = $clog2(N);
   localparam int FL_W  = $clog2(3*N-2);
   localparam int PW    = 2*DATA_W;
   localparam int MW    = (ACC_W > PW) ? ACC_W : PW;

   localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(N-1);
   localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(3*N-3);

   logic [1:0]          state;
   logic [K_W-1:0]      k_q;
   logic [K_W-1:0]      step;
   logic                sm_q;
   logic                load_done;
   logic [FL_W-1:0]     flush_cnt;
   logic                accept;
   logic                clear;
   logic [N*DATA_W-1:0] feed_a;
   logic [N*DATA_W-1:0] feed_b;

   logic [DATA_W-1:0]   a_edge [N];
   logic [DATA_W-1:0]   b_edge [N];
   logic [DATA_W-1:0]   a_reg  [N][N-1];
   logic [DATA_W-1:0]   b_reg  [N-1][N];
   logic [ACC_W-1:0]    acc    [N][N];

   // load_done marks the one tail cycle after the final accept, before FLUSH
   assign a_ready = (state == LOAD) && !load_done;
   assign accept  = a_valid && a_ready;
   assign clear   = (state == IDLE) && start;
   assign busy    = (state != IDLE);
   assign c_valid = (state == DRAIN);
   assign feed_a  = accept ? a_vec : '0;
   assign feed_b  = accept ? b_vec : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         k_q       <= '0;
         step      <= '0;
         sm_q      <= 1'b0;
         load_done <= 1'b0;
         flush_cnt <= '0;
         c_row_idx <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  k_q       <= k_len;
                  sm_q      <= signed_mode;
                  step      <= '0;
                  load_done <= 1'b0;
                  flush_cnt <= '0;
                  c_row_idx <= '0;
                  state     <= (k_len == '0) ? FLUSH : LOAD;
               end
            end
            LOAD: begin
               if (load_done) begin
                  state <= FLUSH;
               end else if (accept) begin
                  step <= step + 1'b1;
                  if (step == k_q - 1'b1) load_done <= 1'b1;
               end
            end
            FLUSH: begin
               if (flush_cnt == FLUSH_LAST) state <= DRAIN;
               else                         flush_cnt <= flush_cnt + 1'b1;
            end
            DRAIN: begin
               if (c_ready) begin
                  if (c_row_idx == LAST_ROW) begin
                     c_row_idx <= '0;
                     state     <= IDLE;
                     done      <= 1'b1;
                  end else begin
                     c_row_idx <= c_row_idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar l = 0; l < N; l++) begin : g_skew
      if (l == 0) begin : g_direct
         assign a_edge[l] = feed_a[l*DATA_W +: DATA_W];
         assign b_edge[l] = feed_b[l*DATA_W +: DATA_W];
      end else begin : g_delay
         logic [DATA_W-1:0] a_sr [l];
         logic [DATA_W-1:0] b_sr [l];
         always_ff @(posedge clk) begin
            if (!reset) begin
               for (int d = 0; d < l; d++) begin
                  a_sr[d] <= '0;
                  b_sr[d] <= '0;
               end
            end else begin
               a_sr[0] <= feed_a[l*DATA_W +: DATA_W];
               b_sr[0] <= feed_b[l*DATA_W +: DATA_W];
               for (int d = 1; d < l; d++) begin
                  a_sr[d] <= a_sr[d-1];
                  b_sr[d] <= b_sr[d-1];
               end
            end
         end
         assign a_edge[l] = a_sr[l-1];
         assign b_edge[l] = b_sr[l-1];
      end
   end

   // Operands are extended to MW bits so the low ACC_W product bits are exact in both modes
   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_pe
         logic [DATA_W-1:0] a_in;
         logic [DATA_W-1:0] b_in;
         logic [MW-1:0]     a_ext;
         logic [MW-1:0]     b_ext;
         logic [MW-1:0]     prod;

         if (j == 0) begin : g_a_edge
            assign a_in = a_edge[i];
         end else begin : g_a_hop
            assign a_in = a_reg[i][j-1];
         end
         if (i == 0) begin : g_b_edge
            assign b_in = b_edge[j];
         end else begin : g_b_hop
            assign b_in = b_reg[i-1][j];
         end

         assign a_ext = {{(MW-DATA_W){sm_q & a_in[DATA_W-1]}}, a_in};
         assign b_ext = {{(MW-DATA_W){sm_q & b_in[DATA_W-1]}}, b_in};
         assign prod  = a_ext * b_ext;

         always_ff @(posedge clk) begin
            if (!reset || clear) acc[i][j] <= '0;
            else                 acc[i][j] <= acc[i][j] + prod[ACC_W-1:0];
         end

         if (j < N-1) begin : g_a_pass
            always_ff @(posedge clk) begin
               if (!reset) a_reg[i][j] <= '0;
               else        a_reg[i][j] <= a_in;
            end
         end
         if (i < N-1) begin : g_b_pass
            always_ff @(posedge clk) begin
               if (!reset) b_reg[i][j] <= '0;
               else        b_reg[i][j] <= b_in;
            end
         end
      end
   end

   always_comb begin
      c_row = '0;
      for (int j = 0; j < N; j++) c_row[j*ACC_W +: ACC_W] = acc[c_row_idx][j];
   end

endmodule

// File: tb/tb_systolic_mac_array_nxn.sv
// Scoreboard bench for systolic_mac_array_nxn: a 32-bit and a 16-bit accumulator
// instance run the same directed jobs; a negedge monitor checks every drained row.
module tb_systolic_mac_array_nxn;

   localparam int N = 4;

   logic         clk;
   logic         reset;
   logic         start;
   logic [7:0]   k_len;
   logic         signed_mode;
   logic         a_valid;
   logic [31:0]  a_vec;
   logic [31:0]  b_vec;
   logic         c_ready;

   logic         a_ready, busy, done, c_valid;
   logic [1:0]   c_row_idx;
   logic [127:0] c_row;
   logic         a_ready16, busy16, done16, c_valid16;
   logic [1:0]   c_row_idx16;
   logic [63:0]  c_row16;

   typedef struct {
      logic [1:0]   idx;
      logic [127:0] row;
      logic [63:0]  row16;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] exp_c [N][N];
   logic [31:0] a_mem [16];
   logic [31:0] b_mem [16];
   int          cmp_cnt  = 0;
   int          fail_cnt = 0;
   int          done_cnt = 0;
   logic        prev_last_hs = 1'b0;

   systolic_mac_array_nxn #(.N(4), .DATA_W(8), .ACC_W(32), .K_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len), .signed_mode(signed_mode),
      .a_valid(a_valid), .a_ready(a_ready), .a_vec(a_vec), .b_vec(b_vec),
      .busy(busy), .done(done), .c_valid(c_valid), .c_ready(c_ready),
      .c_row_idx(c_row_idx), .c_row(c_row)
   );

   systolic_mac_array_nxn #(.N(4), .DATA_W(8), .ACC_W(16), .K_W(8)) dut16 (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len), .signed_mode(signed_mode),
      .a_valid(a_valid), .a_ready(a_ready16), .a_vec(a_vec), .b_vec(b_vec),
      .busy(busy16), .done(done16), .c_valid(c_valid16), .c_ready(c_ready),
      .c_row_idx(c_row_idx16), .c_row(c_row16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string nm, input logic [127:0] act, input logic [127:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check_reset_state(input string nm);
      check_output({nm, "_a_ready"},   128'(a_ready),     128'(0));
      check_output({nm, "_busy"},      128'(busy),        128'(0));
      check_output({nm, "_done"},      128'(done),        128'(0));
      check_output({nm, "_c_valid"},   128'(c_valid),     128'(0));
      check_output({nm, "_c_row_idx"}, 128'(c_row_idx),   128'(0));
      check_output({nm, "_c_row"},     c_row,             128'(0));
      check_output({nm, "_a_ready16"}, 128'(a_ready16),   128'(0));
      check_output({nm, "_busy16"},    128'(busy16),      128'(0));
      check_output({nm, "_c_valid16"}, 128'(c_valid16),   128'(0));
      check_output({nm, "_c_idx16"},   128'(c_row_idx16), 128'(0));
      check_output({nm, "_c_row16"},   128'(c_row16),     128'(0));
   endtask

   task automatic set_uniform(input logic [7:0] av, input logic [7:0] bv, input logic [31:0] cv);
      for (int s = 0; s < 16; s++) begin
         a_mem[s] = {4{av}};
         b_mem[s] = {4{bv}};
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) exp_c[i][j] = cv;
   endtask

   // Runs one job: pushes expected rows, feeds k steps (optionally with bubbles),
   // checks first-c_valid latency, then lets the monitor drain and waits for done.
   task automatic apply_stimulus(input int k, input bit sm, input int gap, input bit bp, input bit poke);
      int   lat;
      int   guard;
      int   exp_lat;
      int   d0;
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.idx   = 2'(i);
         e.row   = '0;
         e.row16 = '0;
         for (int j = 0; j < N; j++) begin
            e.row[j*32 +: 32]   = exp_c[i][j];
            e.row16[j*16 +: 16] = exp_c[i][j][15:0];
         end
         exp_q.push_back(e);
      end
      exp_lat = (k == 0) ? 3*N-1 : 1 + k + 1 + (3*N-2) + gap*(k-1);
      d0 = done_cnt;

      start = 1'b1;
      k_len = 8'(k);
      signed_mode = sm;
      tick();
      start = 1'b0;
      lat = 1;
      for (int s = 0; s < k; s++) begin
         a_valid = 1'b1;
         a_vec   = a_mem[s];
         b_vec   = b_mem[s];
         check_output("a_ready_load", 128'(a_ready), 128'(1));
         tick();
         lat++;
         if (s < k-1) begin
            for (int g = 0; g < gap; g++) begin
               a_valid = 1'b0;
               a_vec   = $urandom;
               b_vec   = $urandom;
               check_output("a_ready_gap", 128'(a_ready), 128'(1));
               tick();
               lat++;
            end
         end
      end
      if (k > 0) check_output("a_ready_tail", 128'(a_ready), 128'(0));

      guard = 0;
      while (!c_valid && guard < 500) begin
         a_valid = 1'b1;
         a_vec   = $urandom;
         b_vec   = $urandom;
         tick();
         lat++;
         guard++;
      end
      a_valid = 1'b0;
      check_output("c_valid_seen", 128'(c_valid), 128'(1));
      check_output("first_c_valid_latency", 128'(lat), 128'(exp_lat));

      if (poke) begin
         start = 1'b1;
         k_len = 8'd5;
      end
      tick();
      start = 1'b0;
      if (bp) begin
         c_ready = 1'b0;
         repeat (5) tick();
         c_ready = 1'b1;
      end

      guard = 0;
      while (done_cnt == d0 && guard < 100) begin
         tick();
         guard++;
      end
      tick();
      check_output("done_pulses", 128'(done_cnt - d0), 128'(1));
      check_output("busy_after_job", 128'(busy), 128'(0));
      check_output("queue_drained", 128'(exp_q.size()), 128'(0));
   endtask

   // Monitor: compare every presented row against the scoreboard head; pop on handshake
   always @(negedge clk) begin
      if (reset) begin
         if (done) begin
            done_cnt++;
            check_output("done_after_last_row", 128'(prev_last_hs), 128'(1));
            check_output("done_c_valid_low", 128'(c_valid), 128'(0));
            check_output("done16", 128'(done16), 128'(1));
         end
         if (c_valid) begin
            if (exp_q.size() == 0) begin
               cmp_cnt++;
               fail_cnt++;
               $display("[TB] FAIL unexpected_row: got idx %0d want no row", c_row_idx);
            end else begin
               mon_e = exp_q[0];
               check_output("c_row_idx", 128'(c_row_idx), 128'(mon_e.idx));
               check_output("c_row", c_row, mon_e.row);
               check_output("c_valid16", 128'(c_valid16), 128'(1));
               check_output("c_row16", 128'(c_row16), 128'(mon_e.row16));
               if (c_ready) void'(exp_q.pop_front());
            end
         end
         prev_last_hs = c_valid && c_ready && (c_row_idx == 2'd3);
      end else begin
         prev_last_hs = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b0;
      start = 1'b0;
      k_len = '0;
      signed_mode = 1'b0;
      a_valid = 1'b0;
      a_vec = '0;
      b_vec = '0;
      c_ready = 1'b1;
      repeat (3) tick();
      check_reset_state("reset");
      reset = 1'b1;
      tick();

      // Identity: A = I, B[k][j] = 16k+j, so C[i][j] = 16i+j
      for (int s = 0; s < 16; s++) begin
         a_mem[s] = '0;
         b_mem[s] = '0;
      end
      for (int s = 0; s < N; s++)
         for (int l = 0; l < N; l++) begin
            a_mem[s][l*8 +: 8] = (l == s) ? 8'd1 : 8'd0;
            b_mem[s][l*8 +: 8] = 8'(16*s + l);
         end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) exp_c[i][j] = 32'(16*i + j);
      $display("[TB] identity job");
      apply_stimulus(4, 1'b0, 0, 1'b0, 1'b0);

      $display("[TB] signed/unsigned extremes");
      set_uniform(8'h80, 8'h80, 32'd65536);
      apply_stimulus(4, 1'b1, 0, 1'b0, 1'b0);
      apply_stimulus(4, 1'b0, 0, 1'b0, 1'b0);
      set_uniform(8'h80, 8'h01, 32'hFFFF_FE00);
      apply_stimulus(4, 1'b1, 0, 1'b0, 1'b0);
      set_uniform(8'h80, 8'h01, 32'd512);
      apply_stimulus(4, 1'b0, 0, 1'b0, 1'b0);

      // A[i][k] = i+1, B[k][j] = j+1 over 3 steps: C[i][j] = 3(i+1)(j+1)
      for (int s = 0; s < 16; s++)
         for (int l = 0; l < N; l++) begin
            a_mem[s][l*8 +: 8] = 8'(l + 1);
            b_mem[s][l*8 +: 8] = 8'(l + 1);
         end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) exp_c[i][j] = 32'(3*(i+1)*(j+1));
      $display("[TB] ramp job with backpressure, then with bubbles");
      apply_stimulus(3, 1'b0, 0, 1'b1, 1'b0);
      apply_stimulus(3, 1'b0, 2, 1'b0, 1'b0);

      $display("[TB] reset mid-LOAD");
      set_uniform(8'hFF, 8'h7F, 32'd0);
      start = 1'b1;
      k_len = 8'd4;
      signed_mode = 1'b0;
      tick();
      start = 1'b0;
      for (int s = 0; s < 2; s++) begin
         a_valid = 1'b1;
         a_vec   = a_mem[s];
         b_vec   = b_mem[s];
         tick();
      end
      a_valid = 1'b0;
      reset = 1'b0;
      tick();
      check_reset_state("mid_load_reset");
      reset = 1'b1;
      tick();
      set_uniform(8'h01, 8'h01, 32'd1);
      apply_stimulus(1, 1'b0, 0, 1'b0, 1'b1);

      $display("[TB] k_len = 0 job");
      set_uniform(8'h55, 8'h33, 32'd0);
      apply_stimulus(0, 1'b0, 0, 1'b0, 1'b0);

      // 2 * 255 * 255 = 130050; the 16-bit instance wraps to 64514
      $display("[TB] accumulator wrap job");
      set_uniform(8'hFF, 8'hFF, 32'd130050);
      apply_stimulus(2, 1'b0, 0, 1'b0, 1'b0);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

endmodule
